// File: rtl/data_mem_arbiter_if.sv
// Purpose: bundles every signal that crosses the data_mem_arbiter boundary
//   except clock and reset. It carries two requester ports (p0 = CPU load/store
//   unit, p1 = debug/DMA loader), the single-ported memory pins and the busy flag.
// Modports:
//   slave  - arbiter view: requests and mem_read_data in; acks, responses,
//            memory controls and busy out
//   master - environment view (requesters + memory), the mirror image
// Signals:
//   pN_req/pN_we/pN_addr/pN_wdata        requester N command, held until pN_ack
//   pN_ack/pN_rdata/pN_err                requester N response
//   memread/memwrite/mem_address/mem_write_data/mem_read_data  memory pins
//   busy                                  arbiter is mid-access
interface data_mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_err;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_err;

  logic              memread;
  logic              memwrite;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  logic              busy;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_read_data,
    output p0_ack, p0_rdata, p0_err,
    output p1_ack, p1_rdata, p1_err,
    output memread, memwrite, mem_address, mem_write_data,
    output busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_read_data,
    input  p0_ack, p0_rdata, p0_err,
    input  p1_ack, p1_rdata, p1_err,
    input  memread, memwrite, mem_address, mem_write_data,
    input  busy
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Purpose: shares one single-ported data memory between two requesters.
//   Arbitration is round-robin. One word access runs at a time through the
//   IDLE -> ACCESS -> DONE sequence, and each access ends with a registered
//   response and a one-cycle ack pulse to the winning port.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset
//   bus    - data_mem_arbiter_if.slave: both requester ports, memory pins, busy
module data_mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              lastGrant_q, lastGrant_d;
  logic              grantId_q, grantId_d;
  logic              we_q, we_d;
  logic              bad_q, bad_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              winner;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic [DATA_W-1:0] accessRdata;

  // State and latch registers. Reset returns to IDLE with lastGrant pointing at
  // port 1, so port 0 wins the first tie, and clears every latched field. An
  // asynchronous reset during ACCESS drops memwrite at once, because memwrite is
  // decoded from the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      grantId_q   <= 1'b0;
      we_q        <= 1'b0;
      bad_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      grantId_q   <= grantId_d;
      we_q        <= we_d;
      bad_q       <= bad_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Next-state logic. In IDLE a single request wins outright. When both ports
  // request, the port that was not granted last wins. lastGrant records every
  // grant so that two ports holding their requests alternate. The winner's command
  // and its legality check are captured together. Each port has its own rdata
  // register, so one port's response is not overwritten by the other's
  // accesses.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    grantId_d   = grantId_q;
    we_d        = we_q;
    bad_d       = bad_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    accessRdata = '0;

    if (bus.p0_req && bus.p1_req) begin
      winner = ~lastGrant_q;
    end else begin
      winner = bus.p1_req;
    end
    selWe    = winner ? bus.p1_we    : bus.p0_we;
    selAddr  = winner ? bus.p1_addr  : bus.p0_addr;
    selWdata = winner ? bus.p1_wdata : bus.p0_wdata;

    unique case (state_q)
      IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          state_d     = ACCESS;
          lastGrant_d = winner;
          grantId_d   = winner;
          we_d        = selWe;
          addr_d      = selAddr;
          wdata_d     = selWdata;
          bad_d       = (selAddr[1:0] != 2'b00) ||
                        (selAddr[ADDR_W-1:MEM_AW+2] != '0);
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (!we_q && !bad_q) begin
          accessRdata = bus.mem_read_data;
        end
        if (grantId_q) begin
          rdata1_d = accessRdata;
        end else begin
          rdata0_d = accessRdata;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode. The memory address and write data always show the latched
  // command. Memory enables are active only in ACCESS and only for a legal
  // access. The ack and err outputs go only to the recorded winner.
  always_comb begin
    bus.mem_address    = addr_q;
    bus.mem_write_data = wdata_q;
    bus.memread        = (state_q == ACCESS) && !we_q && !bad_q;
    bus.memwrite       = (state_q == ACCESS) &&  we_q && !bad_q;
    bus.p0_ack         = (state_q == DONE) && !grantId_q;
    bus.p1_ack         = (state_q == DONE) &&  grantId_q;
    bus.p0_err         = (state_q == DONE) && !grantId_q && bad_q;
    bus.p1_err         = (state_q == DONE) &&  grantId_q && bad_q;
    bus.p0_rdata       = rdata0_q;
    bus.p1_rdata       = rdata1_q;
    bus.busy           = (state_q != IDLE);
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Purpose: directed testbench for data_mem_arbiter. It models a 256-word data
//   memory with a combinational read and a write on the clock edge, then drives
//   the two requester ports through a fixed sequence and checks the responses
//   against hand-computed values.
// Ports: none (top-level bench).
module tb_data_mem_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int MEM_AW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        loadMem;
  logic [31:0] mem [256];
  int          checks   = 0;
  int          failures = 0;
  int          wrCnt    = 0;
  int          rdCnt    = 0;
  int          ack0Cnt  = 0;
  int          ack1Cnt  = 0;
  int          base;

  data_mem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  data_mem_arbiter #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .MEM_AW(MEM_AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock with a 10-time-unit period.
  always #5 clk = ~clk;

  // Combinational read port of the memory model.
  assign bus.mem_read_data = mem[bus.mem_address[MEM_AW+1:2]];

  // The memory model is preloaded with 0x1000_0000 + index and writes on the
  // clock edge. The same block counts memory enables and acks so that tests
  // can check how many of each occurred.
  always @(posedge clk) begin
    if (loadMem) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] <= 32'h1000_0000 + 32'(i);
      end
    end else if (bus.memwrite) begin
      mem[bus.mem_address[MEM_AW+1:2]] <= bus.mem_write_data;
    end
    if (bus.memwrite) wrCnt <= wrCnt + 1;
    if (bus.memread)  rdCnt <= rdCnt + 1;
    if (bus.p0_ack)   ack0Cnt <= ack0Cnt + 1;
    if (bus.p1_ack)   ack1Cnt <= ack1Cnt + 1;
  end

  // Compare one 32-bit value and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Compare one single-bit value and count the result.
  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Raise a request on one port. This is called at a falling edge.
  task automatic applyStimulus(input int port, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_req = 1'b1;
    end else begin
      bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_req = 1'b1;
    end
  endtask

  // Wait (bounded) for the next ack, then check the latency in falling edges,
  // the winner, that the other port saw no ack, and the response fields.
  task automatic waitAck(input int port, input string tag, input int expLat,
                         input logic [31:0] expRdata, input logic expErr);
    logic [31:0] n;
    logic        seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (bus.p0_ack || bus.p1_ack) seen = 1'b1;
    end
    checkBit({tag, "_ack_seen"}, seen, 1'b1);
    checkOutput({tag, "_latency"}, n, 32'(expLat));
    if (port == 0) begin
      checkBit({tag, "_p0_ack"}, bus.p0_ack, 1'b1);
      checkBit({tag, "_p1_ack"}, bus.p1_ack, 1'b0);
      checkOutput({tag, "_p0_rdata"}, bus.p0_rdata, expRdata);
      checkBit({tag, "_p0_err"}, bus.p0_err, expErr);
    end else begin
      checkBit({tag, "_p1_ack"}, bus.p1_ack, 1'b1);
      checkBit({tag, "_p0_ack"}, bus.p0_ack, 1'b0);
      checkOutput({tag, "_p1_rdata"}, bus.p1_rdata, expRdata);
      checkBit({tag, "_p1_err"}, bus.p1_err, expErr);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    reset   = 1'b1;
    loadMem = 1'b1;
    @(negedge clk);
    @(negedge clk);
    loadMem = 1'b0;

    // Reset state: every output is zero.
    checkBit("rst_p0_ack", bus.p0_ack, 1'b0);
    checkBit("rst_p1_ack", bus.p1_ack, 1'b0);
    checkBit("rst_p0_err", bus.p0_err, 1'b0);
    checkBit("rst_p1_err", bus.p1_err, 1'b0);
    checkOutput("rst_p0_rdata", bus.p0_rdata, 32'h0);
    checkOutput("rst_p1_rdata", bus.p1_rdata, 32'h0);
    checkBit("rst_memread", bus.memread, 1'b0);
    checkBit("rst_memwrite", bus.memwrite, 1'b0);
    checkOutput("rst_mem_address", bus.mem_address, 32'h0);
    checkOutput("rst_mem_wdata", bus.mem_write_data, 32'h0);
    checkBit("rst_busy", bus.busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // P0 write, then read back the same word.
    base = wrCnt;
    applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    waitAck(0, "t1_wr", 2, 32'h0, 1'b0);
    bus.p0_req = 1'b0;
    @(negedge clk);
    checkOutput("t1_wr_count", 32'(wrCnt - base), 32'd1);
    base = rdCnt;
    applyStimulus(0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    checkBit("t1_busy_access", bus.busy, 1'b1);
    checkBit("t1_memread_access", bus.memread, 1'b1);
    waitAck(0, "t1_rd", 1, 32'hDEAD_BEEF, 1'b0);
    bus.p0_req = 1'b0;
    checkOutput("t1_rd_count", 32'(rdCnt - base), 32'd1);
    checkOutput("t1_mem_address_held", bus.mem_address, 32'h10);
    @(negedge clk);

    // Both ports request together after reset and hold; grants alternate.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    base = ack1Cnt;
    applyStimulus(0, 1'b0, 32'h10, 32'h0);
    applyStimulus(1, 1'b0, 32'h20, 32'h0);
    waitAck(0, "t2_g0", 2, 32'hDEAD_BEEF, 1'b0);
    waitAck(1, "t2_g1", 3, 32'h1000_0008, 1'b0);
    waitAck(0, "t2_g2", 3, 32'hDEAD_BEEF, 1'b0);
    waitAck(1, "t2_g3", 3, 32'h1000_0008, 1'b0);
    checkOutput("t2_p0_rdata_kept", bus.p0_rdata, 32'hDEAD_BEEF);
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    @(negedge clk);
    checkOutput("t2_p1_ack_count", 32'(ack1Cnt - base), 32'd2);

    // Illegal accesses from P1: misaligned read, then out-of-range write.
    base = wrCnt + rdCnt;
    applyStimulus(1, 1'b0, 32'h3, 32'h0);
    waitAck(1, "t3_misaligned", 2, 32'h0, 1'b1);
    bus.p1_req = 1'b0;
    @(negedge clk);
    applyStimulus(1, 1'b1, 32'h400, 32'hCAFE_F00D);
    waitAck(1, "t3_range", 2, 32'h0, 1'b1);
    bus.p1_req = 1'b0;
    @(negedge clk);
    checkOutput("t3_no_mem_enables", 32'(wrCnt + rdCnt - base), 32'd0);
    applyStimulus(0, 1'b0, 32'h0, 32'h0);
    waitAck(0, "t3_word0", 2, 32'h1000_0000, 1'b0);
    bus.p0_req = 1'b0;
    @(negedge clk);

    // Top word of the memory.
    applyStimulus(0, 1'b1, 32'h3FC, 32'hA5A5_5A5A);
    waitAck(0, "t4_wr", 2, 32'h0, 1'b0);
    bus.p0_req = 1'b0;
    @(negedge clk);
    applyStimulus(0, 1'b0, 32'h3FC, 32'h0);
    waitAck(0, "t4_rd", 2, 32'hA5A5_5A5A, 1'b0);
    bus.p0_req = 1'b0;
    @(negedge clk);

    // Reset in the ACCESS cycle of a P1 write: no commit, no ack.
    base = ack1Cnt;
    applyStimulus(1, 1'b1, 32'h20, 32'h0000_1234);
    @(posedge clk);
    #1;
    checkBit("t5_memwrite_before", bus.memwrite, 1'b1);
    reset = 1'b1;
    #1;
    checkBit("t5_memwrite_reset", bus.memwrite, 1'b0);
    checkBit("t5_busy_reset", bus.busy, 1'b0);
    bus.p1_req = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t5_word8_kept", mem[8], 32'h1000_0008);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t5_no_p1_ack", 32'(ack1Cnt - base), 32'd0);
    checkBit("t5_idle", bus.busy, 1'b0);
    checkOutput("t5_word8_final", mem[8], 32'h1000_0008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
